// File: rtl/prime_test_sequencer.sv
// prime_test_sequencer
// Control FSM for the prime-detection datapath. A test number accepted on
// start is first sent to the square-root engine. Trial division then runs
// through the shared remainder engine with divisors 2,3,5,7,... up to
// floor(sqrt(n)). The FSM reports prime/not-prime, how many divisions were
// issued and how many cycles the test took. Every output comes from a
// flop, so the engines and the display logic never see combinational glitches.

module prime_test_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] test_number,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             is_prime,
   output logic [CNT_W-1:0] divisor_count,
   output logic [CNT_W-1:0] cycle_count,
   output logic             sqrt_req,
   output logic [WIDTH-1:0] sqrt_operand,
   input  logic             sqrt_ack,
   input  logic [WIDTH-1:0] sqrt_result,
   output logic             div_req,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   input  logic             div_ack,
   input  logic [WIDTH-1:0] div_remainder
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SQRT_WAIT = 3'd1,
      S_CHECK     = 3'd2,
      S_DIV_WAIT  = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   // Trial divisor is one bit wider than the operand, so d+2 can never wrap
   // back below the root and cause an endless loop.
   localparam logic [WIDTH:0] D_TWO   = {{(WIDTH-1){1'b0}}, 2'b10};
   localparam logic [WIDTH:0] D_THREE = {{(WIDTH-1){1'b0}}, 2'b11};

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_n;
   logic [WIDTH-1:0] r_root;
   logic [WIDTH:0]   r_d;
   logic [WIDTH-1:0] r_divisor;
   logic             r_busy;
   logic             r_done;
   logic             r_is_prime;
   logic             r_sqrt_req;
   logic             r_div_req;
   logic [CNT_W-1:0] r_div_cnt;
   logic [CNT_W-1:0] r_cyc_cnt;

   logic [WIDTH-1:0] w_n_next;
   logic [WIDTH-1:0] w_root_next;
   logic [WIDTH:0]   w_d_next;
   logic [WIDTH-1:0] w_divisor_next;
   logic             w_busy_next;
   logic             w_done_next;
   logic             w_is_prime_next;
   logic             w_sqrt_req_next;
   logic             w_div_req_next;
   logic [CNT_W-1:0] w_div_cnt_next;
   logic [CNT_W-1:0] w_cyc_cnt_next;

   logic             w_accept;
   logic             w_n_small;
   logic             w_active;
   logic             w_abort;
   logic             w_sqrt_fire;
   logic             w_div_fire;
   logic             w_div_exact;
   logic             w_past_root;
   logic [WIDTH:0]   w_d_step;
   logic [CNT_W-1:0] w_div_cnt_inc;
   logic [CNT_W-1:0] w_cyc_cnt_inc;

   // Decoded conditions shared by the next-state and datapath logic.
   // Acks only count while the matching request is actually up, so a late
   // ack after abort or reset falls on the floor.
   assign w_accept    = (r_state == S_IDLE) && start;
   assign w_n_small   = (test_number[WIDTH-1:1] == '0);
   assign w_active    = (r_state == S_SQRT_WAIT) || (r_state == S_CHECK) ||
                        (r_state == S_DIV_WAIT);
   assign w_abort     = abort && w_active;
   assign w_sqrt_fire = sqrt_ack && r_sqrt_req;
   assign w_div_fire  = div_ack && r_div_req;
   assign w_div_exact = (div_remainder == '0);
   assign w_past_root = (r_d > {1'b0, r_root});
   assign w_d_step    = (r_d == D_TWO) ? D_THREE : (r_d + D_TWO);

   assign w_div_cnt_inc = (r_div_cnt == '1) ? r_div_cnt : (r_div_cnt + CNT_W'(1));
   assign w_cyc_cnt_inc = (r_cyc_cnt == '1) ? r_cyc_cnt : (r_cyc_cnt + CNT_W'(1));

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; abort beats any ack that arrives in the same cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = w_n_small ? S_DONE : S_SQRT_WAIT;
            end
         end
         S_SQRT_WAIT: begin
            if (abort) begin
               w_state_next = S_IDLE;
            end else if (w_sqrt_fire) begin
               w_state_next = S_CHECK;
            end
         end
         S_CHECK: begin
            if (abort) begin
               w_state_next = S_IDLE;
            end else if (w_past_root) begin
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_DIV_WAIT;
            end
         end
         S_DIV_WAIT: begin
            if (abort) begin
               w_state_next = S_IDLE;
            end else if (w_div_fire) begin
               w_state_next = w_div_exact ? S_DONE : S_CHECK;
            end
         end
         // The result has already been published in DONE, so an abort there
         // is not allowed to retract it.
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Output and datapath next values; handshake flags follow the next state
   // so that each request rises on state entry and drops after its ack.
   always_comb begin
      w_n_next        = r_n;
      w_root_next     = r_root;
      w_d_next        = r_d;
      w_divisor_next  = r_divisor;
      w_is_prime_next = r_is_prime;
      w_div_cnt_next  = r_div_cnt;
      w_cyc_cnt_next  = r_cyc_cnt;

      w_busy_next     = (w_state_next == S_SQRT_WAIT) || (w_state_next == S_CHECK) ||
                        (w_state_next == S_DIV_WAIT);
      w_done_next     = (w_state_next == S_DONE);
      w_sqrt_req_next = (w_state_next == S_SQRT_WAIT);
      w_div_req_next  = (w_state_next == S_DIV_WAIT);

      // Elapsed cycles: restart at accept, then count every non-idle cycle,
      // including the DONE cycle. An abort freezes the count.
      if (w_accept) begin
         w_cyc_cnt_next = '0;
      end else if ((r_state != S_IDLE) && !w_abort) begin
         w_cyc_cnt_next = w_cyc_cnt_inc;
      end

      if (w_accept) begin
         w_n_next        = test_number;
         w_is_prime_next = 1'b0;
         w_div_cnt_next  = '0;
      end else if (w_abort) begin
         w_is_prime_next = 1'b0;
      end else begin
         case (r_state)
            S_SQRT_WAIT: begin
               if (w_sqrt_fire) begin
                  w_root_next = sqrt_result;
                  w_d_next    = D_TWO;
               end
            end
            S_CHECK: begin
               if (w_past_root) begin
                  w_is_prime_next = 1'b1;
               end else begin
                  // d <= root here, and root fits WIDTH bits, so the top bit is zero.
                  w_divisor_next = r_d[WIDTH-1:0];
                  w_div_cnt_next = w_div_cnt_inc;
               end
            end
            S_DIV_WAIT: begin
               if (w_div_fire) begin
                  if (w_div_exact) begin
                     w_is_prime_next = 1'b0;
                  end else begin
                     w_d_next = w_d_step;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Datapath and output registers, cleared asynchronously so requests drop at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_n        <= '0;
         r_root     <= '0;
         r_d        <= '0;
         r_divisor  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_is_prime <= 1'b0;
         r_sqrt_req <= 1'b0;
         r_div_req  <= 1'b0;
         r_div_cnt  <= '0;
         r_cyc_cnt  <= '0;
      end else begin
         r_n        <= w_n_next;
         r_root     <= w_root_next;
         r_d        <= w_d_next;
         r_divisor  <= w_divisor_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_is_prime <= w_is_prime_next;
         r_sqrt_req <= w_sqrt_req_next;
         r_div_req  <= w_div_req_next;
         r_div_cnt  <= w_div_cnt_next;
         r_cyc_cnt  <= w_cyc_cnt_next;
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign is_prime      = r_is_prime;
   assign divisor_count = r_div_cnt;
   assign cycle_count   = r_cyc_cnt;
   assign sqrt_req      = r_sqrt_req;
   assign sqrt_operand  = r_n;
   assign div_req       = r_div_req;
   assign div_dividend  = r_n;
   assign div_divisor   = r_divisor;

endmodule

// File: tb/tb_prime_test_sequencer.sv
// Testbench for prime_test_sequencer: a table of directed tests with
// hand-computed results, plus hand-written sequences for abort, reset
// and a full-size 32-bit prime. Small engine models answer the requests.

module tb_prime_test_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] test_number;
   logic        abort;
   logic        busy;
   logic        done;
   logic        is_prime;
   logic [31:0] divisor_count;
   logic [31:0] cycle_count;
   logic        sqrt_req;
   logic [31:0] sqrt_operand;
   logic        sqrt_ack;
   logic [31:0] sqrt_result;
   logic        div_req;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic        div_ack;
   logic [31:0] div_remainder;

   prime_test_sequencer #(.WIDTH(32), .CNT_W(32)) dut (
      .clk           (clk),
      .reset         (rst_n),
      .start         (start),
      .test_number   (test_number),
      .abort         (abort),
      .busy          (busy),
      .done          (done),
      .is_prime      (is_prime),
      .divisor_count (divisor_count),
      .cycle_count   (cycle_count),
      .sqrt_req      (sqrt_req),
      .sqrt_operand  (sqrt_operand),
      .sqrt_ack      (sqrt_ack),
      .sqrt_result   (sqrt_result),
      .div_req       (div_req),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_ack       (div_ack),
      .div_remainder (div_remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] n;
      int          sdly;
      logic [31:0] root;
      int          ddly;
      bit          prime;
      int          dcnt;
      int          cyc;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   // engine model controls
   bit          resp_en    = 1'b0;
   int          sqrt_delay = 0;
   logic [31:0] sqrt_val   = 32'd0;
   int          ddly_fixed = 0;
   bit          rand_mode  = 1'b0;
   int          div_idx    = 0;
   int          dly_sum    = 0;

   // monitor results
   int          mon_issues     = 0;
   int          mon_sqrt_rises = 0;
   int          stab_err       = 0;
   logic [31:0] mon_divs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Engine models: answer each request after a programmed number of cycles.
   initial begin
      int s_wait;
      int d_wait;
      int d_target;
      bit d_active;
      s_wait   = 0;
      d_wait   = 0;
      d_target = 0;
      d_active = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_en) begin
            sqrt_ack = 1'b0;
            div_ack  = 1'b0;
            if (sqrt_req) begin
               if (s_wait >= sqrt_delay) begin
                  sqrt_ack    = 1'b1;
                  sqrt_result = sqrt_val;
                  s_wait      = 0;
               end else begin
                  s_wait++;
               end
            end else begin
               s_wait = 0;
            end
            if (div_req) begin
               if (!d_active) begin
                  d_active = 1'b1;
                  d_wait   = 0;
                  if (rand_mode && (div_idx < 64 || div_idx >= 32704))
                     d_target = int'($urandom_range(0, 5));
                  else
                     d_target = ddly_fixed;
                  dly_sum += d_target;
                  div_idx++;
               end
               if (d_wait >= d_target) begin
                  div_ack       = 1'b1;
                  div_remainder = div_dividend % div_divisor;
                  d_active      = 1'b0;
               end else begin
                  d_wait++;
               end
            end else begin
               d_active = 1'b0;
            end
         end
      end
   end

   // Request monitor: records issued divisors and flags operand changes while a request is held.
   initial begin
      logic        p_div_req;
      logic        p_sqrt_req;
      logic [31:0] p_divisor;
      logic [31:0] p_dividend;
      logic [31:0] p_sqop;
      p_div_req  = 1'b0;
      p_sqrt_req = 1'b0;
      p_divisor  = 32'd0;
      p_dividend = 32'd0;
      p_sqop     = 32'd0;
      forever begin
         @(negedge clk);
         if (div_req && !p_div_req) begin
            mon_issues++;
            mon_divs.push_back(div_divisor);
         end
         if (div_req && p_div_req && (div_divisor !== p_divisor || div_dividend !== p_dividend))
            stab_err++;
         if (sqrt_req && !p_sqrt_req)
            mon_sqrt_rises++;
         if (sqrt_req && p_sqrt_req && sqrt_operand !== p_sqop)
            stab_err++;
         p_div_req  = div_req;
         p_sqrt_req = sqrt_req;
         p_divisor  = div_divisor;
         p_dividend = div_dividend;
         p_sqop     = sqrt_operand;
      end
   end

   task automatic run_vec(input vec_t v, input bit rnd);
      int waited;
      int exp_cyc;
      sqrt_delay = v.sdly;
      sqrt_val   = v.root;
      ddly_fixed = v.ddly;
      rand_mode  = rnd;
      div_idx    = 0;
      dly_sum    = 0;
      mon_issues = 0;
      mon_sqrt_rises = 0;
      mon_divs.delete();
      @(negedge clk);
      start       = 1'b1;
      test_number = v.n;
      @(negedge clk);
      start  = 1'b0;
      waited = 1;
      while (!done && waited < 70000) begin
         @(negedge clk);
         waited++;
      end
      exp_cyc = v.cyc + (rnd ? dly_sum : 0);
      chk("done_seen", done, 1);
      chk("done_latency", waited, exp_cyc);
      chk("busy_at_done", busy, 0);
      chk("is_prime", is_prime, v.prime);
      chk("divisor_count", divisor_count, v.dcnt);
      chk("div_transfers", mon_issues, v.dcnt);
      chk("sqrt_transfers", mon_sqrt_rises, (v.n < 2) ? 0 : 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("cycle_count", cycle_count, exp_cyc);
      chk("is_prime_held", is_prime, v.prime);
      $display("test n=%0d prime=%0b divisors=%0d cycles=%0d", v.n, is_prime, divisor_count, cycle_count);
   endtask

   initial begin
      vec_t        vecs[12];
      vec_t        big;
      logic [31:0] exp_divs[4];
      int          w;
      int          pulses;

      //          n            sdly root         ddly prime dcnt cyc
      vecs[0]  = '{32'd0,      0,   32'd0,       0,   1'b0, 0,   1};
      vecs[1]  = '{32'd1,      0,   32'd0,       0,   1'b0, 0,   1};
      vecs[2]  = '{32'd2,      3,   32'd1,       0,   1'b1, 0,   6};
      vecs[3]  = '{32'd3,      0,   32'd1,       0,   1'b1, 0,   3};
      vecs[4]  = '{32'd4,      0,   32'd2,       0,   1'b0, 1,   4};
      vecs[5]  = '{32'd9,      0,   32'd3,       0,   1'b0, 2,   6};
      vecs[6]  = '{32'd25,     0,   32'd5,       0,   1'b0, 3,   8};
      vecs[7]  = '{32'd29,     0,   32'd5,       0,   1'b1, 3,   9};
      vecs[8]  = '{32'd49,     1,   32'd7,       2,   1'b0, 4,   19};
      vecs[9]  = '{32'd15,     2,   32'd3,       0,   1'b0, 2,   8};
      vecs[10] = '{32'd97,     0,   32'd9,       0,   1'b1, 5,   13};
      vecs[11] = '{32'd91,     0,   32'd9,       1,   1'b0, 4,   14};
      big      = '{32'd4294967291, 0, 32'd65535, 0,   1'b1, 32768, 65539};
      exp_divs[0] = 32'd2;
      exp_divs[1] = 32'd3;
      exp_divs[2] = 32'd5;
      exp_divs[3] = 32'd7;

      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      test_number   = 32'd0;
      sqrt_ack      = 1'b0;
      sqrt_result   = 32'd0;
      div_ack       = 1'b0;
      div_remainder = 32'd0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_is_prime", is_prime, 0);
      chk("rst_divisor_count", divisor_count, 0);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_sqrt_req", sqrt_req, 0);
      chk("rst_div_req", div_req, 0);
      chk("rst_sqrt_operand", sqrt_operand, 0);
      chk("rst_div_dividend", div_dividend, 0);
      chk("rst_div_divisor", div_divisor, 0);
      rst_n   = 1'b1;
      resp_en = 1'b1;

      // directed table
      for (int i = 0; i < 12; i++) run_vec(vecs[i], 1'b0);

      // the last table entry is n=91: divisors must be exactly 2,3,5,7
      chk("n91_div_list_len", mon_divs.size(), 4);
      for (int k = 0; k < 4; k++) chk("n91_divisor", mon_divs[k], exp_divs[k]);

      // largest 32-bit prime with random ack delays near both ends of the run
      stab_err = 0;
      run_vec(big, 1'b1);
      chk("big_req_stable", stab_err, 0);

      // abort in DIV_WAIT together with an ack that would have finished the test
      resp_en  = 1'b0;
      sqrt_ack = 1'b0;
      div_ack  = 1'b0;
      @(negedge clk);
      start       = 1'b1;
      test_number = 32'd91;
      @(negedge clk);
      start = 1'b0;
      chk("ab_sqrt_req", sqrt_req, 1);
      chk("ab_busy", busy, 1);
      chk("ab_sqrt_operand", sqrt_operand, 91);
      sqrt_ack    = 1'b1;
      sqrt_result = 32'd9;
      @(negedge clk);
      sqrt_ack = 1'b0;
      chk("ab_sqrt_req_drop", sqrt_req, 0);
      w = 0;
      while (!div_req && w < 10) begin
         @(negedge clk);
         w++;
      end
      chk("ab_div_req", div_req, 1);
      chk("ab_div_divisor", div_divisor, 2);
      abort         = 1'b1;
      div_ack       = 1'b1;
      div_remainder = 32'd0;
      @(negedge clk);
      abort   = 1'b0;
      div_ack = 1'b0;
      chk("ab_busy_off", busy, 0);
      chk("ab_div_req_off", div_req, 0);
      chk("ab_no_done", done, 0);
      chk("ab_is_prime", is_prime, 0);
      chk("ab_divisor_count", divisor_count, 1);
      chk("ab_cycle_count", cycle_count, 2);
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      chk("ab_stays_idle", pulses, 0);
      chk("ab_cycle_frozen", cycle_count, 2);
      // late acks and an abort while idle must change nothing
      div_ack  = 1'b1;
      sqrt_ack = 1'b1;
      @(negedge clk);
      div_ack  = 1'b0;
      sqrt_ack = 1'b0;
      abort    = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      chk("late_ack_busy", busy, 0);
      chk("late_ack_done", done, 0);
      chk("late_ack_div_count", divisor_count, 1);
      $display("abort sequence: busy=%0b done=%0b divisor_count=%0d", busy, done, divisor_count);
      resp_en = 1'b1;
      run_vec(vecs[10], 1'b0);

      // start held high through a test, then reset pulse while in SQRT_WAIT
      sqrt_delay = 1000;
      sqrt_val   = 32'd9;
      @(negedge clk);
      start       = 1'b1;
      test_number = 32'd91;
      @(negedge clk);
      chk("hold_busy", busy, 1);
      chk("hold_sqrt_req", sqrt_req, 1);
      test_number = 32'd5;
      repeat (4) @(negedge clk);
      chk("hold_cycle_count", cycle_count, 4);
      chk("hold_sqrt_operand", sqrt_operand, 91);
      chk("hold_busy_still", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_sqrt_req", sqrt_req, 0);
      chk("mid_rst_sqrt_operand", sqrt_operand, 0);
      chk("mid_rst_cycle_count", cycle_count, 0);
      @(negedge clk);
      chk("in_rst_busy", busy, 0);
      chk("in_rst_done", done, 0);
      rst_n = 1'b1;
      start = 1'b0;
      $display("reset sequence: busy=%0b sqrt_req=%0b", busy, sqrt_req);
      run_vec(vecs[7], 1'b0);

      chk("req_stable_all", stab_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
